// File: rtl/decode_unit.sv
// RV32I ID stage: IF/ID register, decode, immediate extraction, redirect to fetch, EX handshake.
// Optional DECODE_ILLEGAL_TRAP_EN: flag illegal opcodes on illegal_o instead of issuing them as NOPs.
module decode_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_i,
    input  logic [31:0]       inst_i,
    input  logic [31:0]       pc_i,
    output logic              ready_o,
    input  logic              misspredict_i,
    output logic              jmp_o,
    output logic              branch_o,
    output logic [ADDR_W-1:0] jmp_target_o,
    output logic              inst31_o,
    output logic [4:0]        rs1_addr_o,
    output logic [4:0]        rs2_addr_o,
    input  logic [31:0]       rs1_data_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [31:0]       pc_o,
    output logic [6:0]        opcode_o,
    output logic [2:0]        funct3_o,
    output logic              funct7b5_o,
    output logic [4:0]        rd_o,
    output logic [31:0]       imm_o,
    output logic              illegal_o
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    logic        id_valid;
    logic        first;
    logic [31:0] inst_q;
    logic [31:0] pc_q;
    logic        capture;
    logic        issue;

    assign ready_o = !id_valid || ready_i;
    assign capture = valid_i && ready_o && !misspredict_i;
    assign issue   = id_valid && ready_i;
    assign valid_o = id_valid && !misspredict_i;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            id_valid <= 1'b0;
            first    <= 1'b0;
            inst_q   <= '0;
            pc_q     <= '0;
        end else if (misspredict_i) begin
            id_valid <= 1'b0;
            first    <= 1'b0;
        end else if (capture) begin
            id_valid <= 1'b1;
            first    <= 1'b1;
            inst_q   <= inst_i;
            pc_q     <= pc_i;
        end else begin
            // first is a one-cycle marker so a stalled jump redirects fetch only once
            first <= 1'b0;
            if (issue) id_valid <= 1'b0;
        end
    end

    logic [6:0]  opcode;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [31:0] imm;
    logic        legal, is_jal, is_jalr, is_branch, no_rd;

    assign opcode = inst_q[6:0];
    assign imm_i  = {{20{inst_q[31]}}, inst_q[31:20]};
    assign imm_s  = {{20{inst_q[31]}}, inst_q[31:25], inst_q[11:7]};
    assign imm_b  = {{19{inst_q[31]}}, inst_q[31], inst_q[7], inst_q[30:25], inst_q[11:8], 1'b0};
    assign imm_u  = {inst_q[31:12], 12'b0};
    assign imm_j  = {{11{inst_q[31]}}, inst_q[31], inst_q[19:12], inst_q[20], inst_q[30:21], 1'b0};

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        legal     = 1'b1;
        imm       = 32'd0;
        is_jal    = 1'b0;
        is_jalr   = 1'b0;
        is_branch = 1'b0;
        no_rd     = 1'b0;
        case (opcode)
            OPC_LUI, OPC_AUIPC: imm = imm_u;
            OPC_JAL: begin
                imm    = imm_j;
                is_jal = 1'b1;
            end
            OPC_JALR: begin
                imm     = imm_i;
                is_jalr = 1'b1;
            end
            OPC_BRANCH: begin
                imm       = imm_b;
                is_branch = 1'b1;
                no_rd     = 1'b1;
            end
            OPC_STORE: begin
                imm   = imm_s;
                no_rd = 1'b1;
            end
            OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM, OPC_FENCE: imm = imm_i;
            OPC_OP: imm = 32'd0;
            default: legal = 1'b0;
        endcase
    end

    logic        redirect_ok;
    logic [31:0] target_full;

    assign redirect_ok = first && id_valid && !misspredict_i;
    assign jmp_o       = redirect_ok && (is_jal || is_jalr);
    assign branch_o    = redirect_ok && is_branch;

    always_comb begin
        target_full = pc_q;
        if (is_jal)         target_full = pc_q + imm_j;
        else if (is_jalr)   target_full = (rs1_data_i + imm_i) & ~32'd1;
        else if (is_branch) target_full = pc_q + imm_b;
    end

    assign jmp_target_o = target_full[ADDR_W-1:0];
    assign inst31_o     = inst_q[31];
    assign rs1_addr_o   = inst_q[19:15];
    assign rs2_addr_o   = inst_q[24:20];
    assign pc_o         = pc_q;
    assign funct3_o     = inst_q[14:12];
    assign funct7b5_o   = inst_q[30];
    assign imm_o        = imm;

`ifdef DECODE_ILLEGAL_TRAP_EN
    assign opcode_o  = opcode;
    assign rd_o      = no_rd ? 5'd0 : inst_q[11:7];
    assign illegal_o = valid_o && !legal;
`else
    // Undecodable opcodes travel down the pipe as a NOP
    assign opcode_o  = legal ? opcode : OPC_OP_IMM;
    assign rd_o      = (no_rd || !legal) ? 5'd0 : inst_q[11:7];
    assign illegal_o = 1'b0;
`endif

endmodule
